// File: rtl/elevator_pkg.sv
// Shared elevator definitions: car state codes, floor width and floor validity helper.
package elevator_pkg;

   localparam int NUM_FLOORS = 5;
   localparam int FLOOR_W    = 3;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_DOOR = 2'd1;
   localparam logic [1:0] ST_UP   = 2'd2;
   localparam logic [1:0] ST_DOWN = 2'd3;

   // Floors are numbered 1..max_floor; 0 and anything above max_floor mean "no request".
   function automatic logic floor_valid(input logic [FLOOR_W-1:0] f, input int max_floor);
      return (f != '0) && (int'(f) <= max_floor);
   endfunction

endpackage

// File: rtl/car_motion_fsm_cycle_timer.sv
// Loadable down-counter shared by the travel and door-dwell phases; holds at zero.
module cycle_timer #(
   parameter int TIMER_W = 27
) (
   input  logic               clk,
   input  logic               resetn,
   input  logic               load,
   input  logic [TIMER_W-1:0] load_val,
   input  logic               dec,
   output logic               zero
);

   logic [TIMER_W-1:0] count_q;
   logic [TIMER_W-1:0] count_d;

   always_comb begin
      count_d = count_q;
      if (load) begin
         count_d = load_val;
      end else if (dec && (count_q != '0)) begin
         count_d = count_q - 1'b1;
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign zero = (count_q == '0);

endmodule

// File: rtl/car_motion_fsm.sv
// Elevator car motion and door controller: floor-to-floor travel, door dwell and arrival pulses.
module car_motion_fsm
   import elevator_pkg::*;
#(
   parameter int NUM_FLOORS    = 5,
   parameter int TRAVEL_CYCLES = 50000000,
   parameter int DOOR_CYCLES   = 100000000,
   parameter int TIMER_W       = 27
) (
   input  logic               clk,
   input  logic               resetn,
   input  logic               enable,
   input  logic [FLOOR_W-1:0] dest,
   input  logic               call_here,
   input  logic               door_hold,
   output logic [1:0]         state,
   output logic [FLOOR_W-1:0] location,
   output logic               door_open,
   output logic               arrive
);

   localparam logic [FLOOR_W-1:0] TOP_FLOOR   = FLOOR_W'(NUM_FLOORS);
   localparam logic [FLOOR_W-1:0] BOT_FLOOR   = FLOOR_W'(1);
   localparam logic [TIMER_W-1:0] TRAVEL_LOAD = TIMER_W'(TRAVEL_CYCLES - 1);
   localparam logic [TIMER_W-1:0] DOOR_LOAD   = TIMER_W'(DOOR_CYCLES - 1);

   logic [1:0]         state_q, state_d;
   logic [FLOOR_W-1:0] loc_q, loc_d;
   logic               door_q, door_d;
   logic               arrive_q, arrive_d;
   logic               tmr_load, tmr_dec, tmr_zero;
   logic [TIMER_W-1:0] tmr_val;
   logic [FLOOR_W-1:0] nl;
   logic               dest_ok;

   assign dest_ok = floor_valid(dest, NUM_FLOORS);

   always_comb begin
      state_d  = state_q;
      loc_d    = loc_q;
      arrive_d = 1'b0;
      tmr_load = 1'b0;
      tmr_dec  = 1'b0;
      tmr_val  = '0;
      nl       = loc_q;
      if (enable) begin
         case (state_q)
            ST_IDLE: begin
               if (call_here) begin
                  state_d  = ST_DOOR;
                  tmr_load = 1'b1;
                  tmr_val  = DOOR_LOAD;
               end else if (dest_ok && (dest > loc_q)) begin
                  state_d  = ST_UP;
                  tmr_load = 1'b1;
                  tmr_val  = TRAVEL_LOAD;
               end else if (dest_ok && (dest < loc_q)) begin
                  state_d  = ST_DOWN;
                  tmr_load = 1'b1;
                  tmr_val  = TRAVEL_LOAD;
               end
            end
            ST_UP, ST_DOWN: begin
               // Moving past an end floor is impossible by construction; park safely.
               if ((state_q == ST_UP && loc_q >= TOP_FLOOR) ||
                   (state_q == ST_DOWN && loc_q <= BOT_FLOOR)) begin
                  state_d = ST_IDLE;
               end else if (tmr_zero) begin
                  nl       = (state_q == ST_UP) ? loc_q + 1'b1 : loc_q - 1'b1;
                  loc_d    = nl;
                  arrive_d = 1'b1;
                  if (dest == nl) begin
                     state_d  = ST_DOOR;
                     tmr_load = 1'b1;
                     tmr_val  = DOOR_LOAD;
                  end else if (dest_ok && (((state_q == ST_UP) && (dest > nl) && (nl < TOP_FLOOR)) ||
                                           ((state_q == ST_DOWN) && (dest < nl) && (nl > BOT_FLOOR)))) begin
                     tmr_load = 1'b1;
                     tmr_val  = TRAVEL_LOAD;
                  end else begin
                     state_d = ST_IDLE;
                  end
               end else begin
                  tmr_dec = 1'b1;
               end
            end
            default: begin
               if (door_hold || call_here) begin
                  tmr_load = 1'b1;
                  tmr_val  = DOOR_LOAD;
               end else if (tmr_zero) begin
                  state_d = ST_IDLE;
               end else begin
                  tmr_dec = 1'b1;
               end
            end
         endcase
      end
      door_d = (state_d == ST_DOOR);
   end

   cycle_timer #(.TIMER_W(TIMER_W)) u_timer (
      .clk      (clk),
      .resetn   (resetn),
      .load     (tmr_load),
      .load_val (tmr_val),
      .dec      (tmr_dec),
      .zero     (tmr_zero)
   );

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q  <= ST_IDLE;
         loc_q    <= BOT_FLOOR;
         door_q   <= 1'b0;
         arrive_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         loc_q    <= loc_d;
         door_q   <= door_d;
         arrive_q <= arrive_d;
      end
   end

   assign state     = state_q;
   assign location  = loc_q;
   assign door_open = door_q;
   assign arrive    = arrive_q;

endmodule

// File: tb/tb_car_motion_fsm.sv
// Directed bench for car_motion_fsm with short travel/door times and an arrival scoreboard.
module tb_car_motion_fsm;

   logic       clk;
   logic       resetn;
   logic       enable;
   logic [2:0] dest;
   logic       call_here;
   logic       door_hold;
   logic [1:0] state;
   logic [2:0] location;
   logic       door_open;
   logic       arrive;

   int checks   = 0;
   int failures = 0;
   logic [2:0] exp_q[$];
   logic [2:0] bad_dest [3];

   car_motion_fsm #(
      .NUM_FLOORS    (5),
      .TRAVEL_CYCLES (4),
      .DOOR_CYCLES   (6),
      .TIMER_W       (27)
   ) dut (
      .clk       (clk),
      .resetn    (resetn),
      .enable    (enable),
      .dest      (dest),
      .call_here (call_here),
      .door_hold (door_hold),
      .state     (state),
      .location  (location),
      .door_open (door_open),
      .arrive    (arrive)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic expect_out(input string tag, input logic [1:0] st, input logic [2:0] loc,
                             input logic dopen, input logic arr);
      check({tag, "_state"}, state, st);
      check({tag, "_location"}, location, loc);
      check({tag, "_door_open"}, door_open, dopen);
      check({tag, "_arrive"}, arrive, arr);
   endtask

   // scoreboard: every arrive pulse must match the next expected floor
   always @(negedge clk) begin
      if (resetn && arrive) begin
         check("arrive_expected", exp_q.size() != 0, 1);
         if (exp_q.size() != 0) check("arrive_floor", location, exp_q.pop_front());
      end
   end

   initial begin
      bad_dest[0] = 3'd0;
      bad_dest[1] = 3'd6;
      bad_dest[2] = 3'd7;
      resetn = 1'b0; enable = 1'b1; dest = 3'd1; call_here = 1'b0; door_hold = 1'b0;
      step(2);
      expect_out("reset", 2'd0, 3'd1, 1'b0, 1'b0);
      resetn = 1'b1;
      step(1);
      check("idle_after_reset", state, 0);

      // 1: floor 1 -> 3
      dest = 3'd3; exp_q.push_back(3'd2); exp_q.push_back(3'd3);
      step(1);
      expect_out("t1_start", 2'd2, 3'd1, 1'b0, 1'b0);
      step(3);
      check("t1_travel_loc", location, 1);
      step(1);
      expect_out("t1_floor2", 2'd2, 3'd2, 1'b0, 1'b1);
      step(4);
      expect_out("t1_floor3", 2'd1, 3'd3, 1'b1, 1'b1);
      step(5);
      expect_out("t1_dwell", 2'd1, 3'd3, 1'b1, 1'b0);
      step(1);
      expect_out("t1_idle", 2'd0, 3'd3, 1'b0, 1'b0);

      // 2: call at floor, door held
      call_here = 1'b1; door_hold = 1'b1;
      step(1);
      check("t2_door", state, 1);
      call_here = 1'b0;
      step(20);
      expect_out("t2_held", 2'd1, 3'd3, 1'b1, 1'b0);
      door_hold = 1'b0;
      step(5);
      check("t2_dwell", state, 1);
      step(1);
      expect_out("t2_idle", 2'd0, 3'd3, 1'b0, 1'b0);

      // 3: up to 5, then down to 1
      dest = 3'd5; exp_q.push_back(3'd4); exp_q.push_back(3'd5);
      step(9);
      expect_out("t3_at5", 2'd1, 3'd5, 1'b1, 1'b1);
      step(6);
      check("t3_idle5", state, 0);
      dest = 3'd1;
      for (int f = 4; f >= 1; f--) exp_q.push_back(3'(f));
      step(1);
      check("t3_down", state, 3);
      for (int f = 4; f >= 1; f--) begin
         step(4);
         check("t3_step_loc", location, f);
         check("t3_step_arrive", arrive, 1);
      end
      check("t3_door1", state, 1);
      step(6);
      check("t3_idle1", state, 0);

      // 4: retarget mid-travel
      dest = 3'd5; exp_q.push_back(3'd2);
      step(1);
      check("t4_up", state, 2);
      step(2);
      dest = 3'd2;
      step(2);
      expect_out("t4_stop2", 2'd1, 3'd2, 1'b1, 1'b1);
      step(6);
      check("t4_idle2", state, 0);
      dest = 3'd5; exp_q.push_back(3'd3);
      step(1);
      check("t4_up_again", state, 2);
      step(2);
      dest = 3'd1;
      step(2);
      expect_out("t4_reverse_idle", 2'd0, 3'd3, 1'b0, 1'b1);
      exp_q.push_back(3'd2); exp_q.push_back(3'd1);
      step(1);
      check("t4_down", state, 3);
      step(8);
      expect_out("t4_back1", 2'd1, 3'd1, 1'b1, 1'b1);
      step(6);
      check("t4_idle1", state, 0);

      // 5: invalid destinations, then enable freeze
      for (int i = 0; i < 3; i++) begin
         dest = bad_dest[i];
         step(3);
         expect_out("t5_bad_dest", 2'd0, 3'd1, 1'b0, 1'b0);
      end
      dest = 3'd2; exp_q.push_back(3'd2);
      step(2);
      enable = 1'b0;
      step(10);
      expect_out("t5_frozen", 2'd2, 3'd1, 1'b0, 1'b0);
      enable = 1'b1;
      step(2);
      check("t5_resume_loc", location, 1);
      step(1);
      expect_out("t5_arrive2", 2'd1, 3'd2, 1'b1, 1'b1);
      enable = 1'b0;
      step(1);
      expect_out("t5_arrive_cleared", 2'd1, 3'd2, 1'b1, 1'b0);
      enable = 1'b1;
      step(5);
      check("t5_dwell", state, 1);
      step(1);
      check("t5_idle", state, 0);

      // 6: async reset mid-travel
      dest = 3'd4;
      step(3);
      check("t6_moving", state, 2);
      resetn = 1'b0;
      #1;
      expect_out("t6_reset", 2'd0, 3'd1, 1'b0, 1'b0);
      dest = 3'd1;
      step(1);
      resetn = 1'b1;
      step(2);
      expect_out("t6_after", 2'd0, 3'd1, 1'b0, 1'b0);
      check("scoreboard_drained", exp_q.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/car_motion_fsm.md
Name: car_motion_fsm

Overview:
Elevator car motion and door controller for the 5-floor design; sits directly downstream of the destination-setter stage. It consumes the current destination floor and a "call pending at this floor" flag, and produces the car state code, current floor and door status. Those outputs feed back into the destination setter and the display logic. It models floor-to-floor travel time and door dwell time with a shared down-counter.

Parameters:
NUM_FLOORS, 5, highest valid floor; floors are numbered 1..NUM_FLOORS.
TRAVEL_CYCLES, 50000000, clk cycles to move one floor (must be >= 1).
DOOR_CYCLES, 100000000, clk cycles the door stays open after the last (re)open event (must be >= 1).
TIMER_W, 27, width of the internal timer; must hold max(TRAVEL_CYCLES, DOOR_CYCLES)-1.

Ports:
clk  input  1  system clock
resetn  input  1  asynchronous, active-low reset
enable  input  1  high: block advances; low: all state, timer and outputs frozen, arrive forced 0
dest  input  3  destination floor from the destination setter; only 1..NUM_FLOORS is valid
call_here  input  1  high when a car or hall call is pending at the current location
door_hold  input  1  door-open button; while high in DOOR, keeps reloading the dwell timer
state  output  2  0=IDLE (stopped, door closed), 1=DOOR (door open), 2=UP, 3=DOWN
location  output  3  current floor, 1..NUM_FLOORS
door_open  output  1  high exactly while state==DOOR (registered)
arrive  output  1  one-cycle pulse, asserted in the same cycle that location takes its new value

Behaviour:
- Reset (async): state=IDLE, location=1, timer=0, door_open=0, arrive=0. Reset mid-travel aborts immediately; there is no partial-floor memory.
- A valid dest satisfies 1<=dest<=NUM_FLOORS. An invalid dest (0, 6, 7) is treated as "no request".
- All transitions are registered, with 1-cycle latency from input to state change.
- IDLE (evaluated in priority order):
  - call_here=1 -> DOOR, timer<=DOOR_CYCLES-1.
  - Else valid dest>location -> UP, timer<=TRAVEL_CYCLES-1.
  - Else valid dest<location -> DOWN, timer<=TRAVEL_CYCLES-1.
  - Else stay in IDLE.
- UP/DOWN:
  - Timer decrements each enabled cycle.
  - When timer==0: location<=location±1, arrive<=1, and next state is chosen using the new floor value nl compared against the dest sampled in that cycle.
  - dest==nl -> DOOR, timer<=DOOR_CYCLES-1.
  - UP with valid dest>nl and nl<NUM_FLOORS -> stay UP, reload TRAVEL_CYCLES-1.
  - DOWN with valid dest<nl and nl>1 -> stay DOWN, reload TRAVEL_CYCLES-1.
  - Otherwise (dest reversed, invalid, or end floor reached) -> IDLE.
  - dest may change freely mid-travel; the car always completes the floor it is moving toward and never reverses between floors.
- Boundary guard: UP at location==NUM_FLOORS, or DOWN at location==1, goes to IDLE without changing location. This state is unreachable by construction but must be safe.
- DOOR:
  - door_hold=1 or call_here=1 -> timer<=DOOR_CYCLES-1 (reopen/extend; the door can be held indefinitely).
  - Else timer decrements; at timer==0 -> IDLE.
  - location never changes in DOOR.
- arrive is 0 in every cycle other than a floor step.
- enable=0: no register updates except arrive, which is cleared. When enable returns high, operation resumes with the exact remaining timer value.
- No arithmetic wrap: location is always within 1..NUM_FLOORS, and the timer never underflows because it is reloaded or left idle at 0.

Decomposition:
- Package elevator_pkg:
  - state codes ST_IDLE=2'd0, ST_DOOR=2'd1, ST_UP=2'd2, ST_DOWN=2'd3 (shared with the destination setter);
  - NUM_FLOORS, FLOOR_W=3;
  - a floor_valid() helper function.
- One sub-module, cycle_timer: a loadable TIMER_W down-counter with load, dec and zero flag. It is reused by the motion and door phases.

Test Plan (TRAVEL_CYCLES=4, DOOR_CYCLES=6):
1. Reset, then dest=3. Expect:
   - state=2 one cycle later;
   - location=2 with an arrive pulse 4 cycles after that; state stays 2;
   - location=3 plus an arrive pulse 4 cycles later, with state=1 and door_open=1;
   - state=0 and door_open=0 6 cycles after that.
2. IDLE at floor 3 with call_here=1 -> DOOR next cycle. Hold door_hold for 20 cycles -> state stays 1. Release door_hold and call_here -> IDLE exactly 6 cycles later.
3. Start at 5 (reached via dest=5) and set dest=1 -> DOWN. Expect 4 arrive pulses spaced 4 cycles apart, location 4,3,2,1, then DOOR at floor 1.
4. From floor 1 with dest=5, change dest to 2 two cycles into travel -> stops at 2 in DOOR. Redo the run and change dest to 1 while between floors 2 and 3 -> arrives at 3, goes IDLE, then DOWN the next cycle.
5. In IDLE, dest=0, 6, 7 -> state stays 0 indefinitely. During UP, drop enable for 10 cycles -> timer and location frozen and arrive=0; the floor step completes after the remaining cycles once enable is high again.
6. Assert resetn low mid-travel between floors 2 and 3 -> immediately state=0, location=1, door_open=0, arrive=0.
